alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, 1 = round-robin grant, 0 = fixed priority (requester 0 wins).
REQ-002 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 reqN_valid (N=0,1)  input  1  requester N presents an operation.
REQ-006 reqN_ready (N=0,1)  output  1  requester N operation accepted this cycle when valid & ready.
REQ-007 reqN_a, reqN_b (N=0,1)  input  8 each  operands.
REQ-008 reqN_op (N=0,1)  input  3  ALU control code.
REQ-009 reqN_samt (N=0,1)  input  4  shift amount.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_id  output  1  requester index owning the response.
REQ-013 rsp_result  output  8  ALU result.
REQ-014 rsp_flags  output  4  {overflow, negative, zero, carry}.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done_cnt  output  CNT_W  count of completed response handshakes.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-018 In IDLE, reqN_ready SHALL be high only for the granted requester; both ready low outside IDLE and while rst high.
REQ-019 Grant: single valid requester wins; both valid -> requester not granted last (RR_EN=1) or requester 0 (RR_EN=0).
REQ-020 Last-grant pointer SHALL update only on an accept; reset value 1, so requester 0 wins first tie.
REQ-021 On accept, operands, op, samt and id SHALL be latched and FSM moves IDLE -> EXEC.
REQ-022 EXEC SHALL last exactly one cycle; ALU driven from latched registers; result, flags and id captured at end of EXEC; FSM -> RESP.
REQ-023 Latency: accept at cycle T -> rsp_valid high at T+2.
REQ-024 Op semantics: 000 A+B; 001 A-B; 010 A&B; 011 A|B; 100 (A+B)<<samt; 101 (A-B)<<samt; 110 (A+B)>>samt; 111 (A-B)>>samt; logical shifts, 8-bit truncation.
REQ-025 Subtract SHALL be A + ~B + 1; carry = adder carry-out; overflow = (A[7]^S[7]) & ~(A[7]^B[7]^cin), S = pre-shift sum.
REQ-026 Carry and overflow SHALL be 0 for op 010; zero = (result==0); negative = result[7].
REQ-027 In RESP, rsp_valid high and all rsp_* held stable until rsp_ready; on handshake FSM -> IDLE, rsp_valid low next cycle, done_cnt increments.
REQ-028 done_cnt SHALL wrap from all-ones to 0.
REQ-029 New accepts SHALL NOT occur in the cycle of a response handshake; minimum 3 cycles per operation.
REQ-030 Requester inputs changing while not accepted SHALL have no effect.

Reset
REQ-031 rst high SHALL force state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0, done_cnt 0, last-grant 1, reqN_ready 0.
REQ-032 Reset in EXEC or RESP SHALL discard the in-flight operation; no response issued, done_cnt not incremented.
REQ-033 rst has priority over any handshake in the same cycle.

Structure
REQ-034 Shared package SHALL hold op-code constants, FSM state encoding, and flag bit positions.
REQ-035 One sub-module: the team's existing 8-bit ALU, instantiated once; grant logic stays inline.

Verification
REQ-036 req0 op 000 A=7F B=01 -> result 80, flags overflow=1 negative=1 zero=0 carry=0, rsp_valid at T+2, rsp_id 0.
REQ-037 req1 op 001 A=05 B=05 -> result 00, zero=1 carry=1 overflow=0 negative=0, rsp_id 1.
REQ-038 After reset both valid continuously, rsp_ready=1, RR_EN=1 -> responses alternate ids 0,1,0,1; RR_EN=0 -> all id 0.
REQ-039 op 100 A=03 B=01 samt=2 -> result 10, all flags 0; op 110 same operands -> result 01.
REQ-040 rsp_ready low 5 cycles in RESP -> rsp_* stable, both reqN_ready low, busy 1; release -> done_cnt +1, IDLE next cycle.
REQ-041 rst pulsed during EXEC -> no rsp_valid, done_cnt 0, next accept served normally with requester 0 priority.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared constants for the two-requester ALU arbiter: data
//               widths, ALU op-codes, FSM state encoding and flag positions.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_OP_W   = 3;
    localparam int c_SAMT_W = 4;
    localparam int c_FLAG_W = 4;

    // ALU control codes
    localparam logic [c_OP_W-1:0] c_OP_ADD     = 3'b000;
    localparam logic [c_OP_W-1:0] c_OP_SUB     = 3'b001;
    localparam logic [c_OP_W-1:0] c_OP_AND     = 3'b010;
    localparam logic [c_OP_W-1:0] c_OP_OR      = 3'b011;
    localparam logic [c_OP_W-1:0] c_OP_ADD_SHL = 3'b100;
    localparam logic [c_OP_W-1:0] c_OP_SUB_SHL = 3'b101;
    localparam logic [c_OP_W-1:0] c_OP_ADD_SHR = 3'b110;
    localparam logic [c_OP_W-1:0] c_OP_SUB_SHR = 3'b111;

    // Flag vector is {overflow, negative, zero, carry}
    localparam int c_FLAG_C = 0;
    localparam int c_FLAG_Z = 1;
    localparam int c_FLAG_N = 2;
    localparam int c_FLAG_V = 3;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_alu
// Description : Combinational 8-bit ALU. Add/subtract share one adder
//               (subtract is A + ~B + 1), optional logical shift of the sum,
//               plus AND/OR. Produces {overflow, negative, zero, carry}.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [c_DATA_W-1:0] a,
    input  logic [c_DATA_W-1:0] b,
    input  logic [c_OP_W-1:0]   op,
    input  logic [c_SAMT_W-1:0] samt,
    output logic [c_DATA_W-1:0] result,
    output logic [c_FLAG_W-1:0] flags
);

    logic                w_sub;
    logic                w_is_logic;
    logic [c_DATA_W-1:0] w_b_eff;
    logic [c_DATA_W-1:0] w_sum;
    logic                w_cout;
    logic                w_ovf;

    // Shared adder; op[0] selects subtract for every arithmetic code
    always_comb begin
        w_sub      = op[0];
        w_is_logic = (op == c_OP_AND) || (op == c_OP_OR);
        w_b_eff    = w_sub ? ~b : b;
        {w_cout, w_sum} = {1'b0, a} + {1'b0, w_b_eff} + 9'(w_sub);
        w_ovf      = (a[7] ^ w_sum[7]) & ~(a[7] ^ b[7] ^ w_sub);
    end

    // Result select and flag generation; carry/overflow are meaningless for logic ops
    always_comb begin
        result = w_sum;
        case (op)
            c_OP_ADD, c_OP_SUB:         result = w_sum;
            c_OP_AND:                   result = a & b;
            c_OP_OR:                    result = a | b;
            c_OP_ADD_SHL, c_OP_SUB_SHL: result = w_sum << samt;
            c_OP_ADD_SHR, c_OP_SUB_SHR: result = w_sum >> samt;
            default:                    result = w_sum;
        endcase
        flags           = '0;
        flags[c_FLAG_C] = w_is_logic ? 1'b0 : w_cout;
        flags[c_FLAG_V] = w_is_logic ? 1'b0 : w_ovf;
        flags[c_FLAG_Z] = (result == '0);
        flags[c_FLAG_N] = result[7];
    end

endmodule : alu_arbiter_alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Arbitrates two valid/ready requesters onto one shared ALU.
//               IDLE -> EXEC (one cycle) -> RESP (held until rsp_ready).
//               Round-robin or fixed-priority grant, completion counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [c_DATA_W-1:0] req0_a,
    input  logic [c_DATA_W-1:0] req0_b,
    input  logic [c_OP_W-1:0]   req0_op,
    input  logic [c_SAMT_W-1:0] req0_samt,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [c_DATA_W-1:0] req1_a,
    input  logic [c_DATA_W-1:0] req1_b,
    input  logic [c_OP_W-1:0]   req1_op,
    input  logic [c_SAMT_W-1:0] req1_samt,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [c_DATA_W-1:0] rsp_result,
    output logic [c_FLAG_W-1:0] rsp_flags,
    output logic                busy,
    output logic [CNT_W-1:0]    done_cnt
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last;
    logic [c_DATA_W-1:0] r_a;
    logic [c_DATA_W-1:0] r_b;
    logic [c_OP_W-1:0]   r_op;
    logic [c_SAMT_W-1:0] r_samt;
    logic                r_id;
    logic [c_DATA_W-1:0] r_rsp_result;
    logic [c_FLAG_W-1:0] r_rsp_flags;
    logic                r_rsp_id;
    logic [CNT_W-1:0]    r_done_cnt;

    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic                w_rsp_hs;
    logic [c_DATA_W-1:0] w_alu_result;
    logic [c_FLAG_W-1:0] w_alu_flags;

    // Grant: lone requester wins; on a tie, requester 0 wins unless it was served last in round-robin mode
    always_comb begin
        w_grant0 = req0_valid & (~req1_valid | (RR_EN == 0) | r_last);
        w_grant1 = req1_valid & ~w_grant0;
    end

    // Next-state and handshake decode; ready is only offered in IDLE and never under reset
    always_comb begin
        w_next_state = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        w_accept     = 1'b0;
        w_rsp_hs     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = ~rst & w_grant0;
                req1_ready = ~rst & w_grant1;
                w_accept   = ~rst & (w_grant0 | w_grant1);
                if (w_accept) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_hs = rsp_ready;
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture on accept; the last-grant pointer moves only here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_samt <= '0;
            r_id   <= 1'b0;
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_a    <= w_grant1 ? req1_a    : req0_a;
            r_b    <= w_grant1 ? req1_b    : req0_b;
            r_op   <= w_grant1 ? req1_op   : req0_op;
            r_samt <= w_grant1 ? req1_samt : req0_samt;
            r_id   <= w_grant1;
            r_last <= w_grant1;
        end
    end

    alu_arbiter_alu u_alu (
        .a      (r_a),
        .b      (r_b),
        .op     (r_op),
        .samt   (r_samt),
        .result (w_alu_result),
        .flags  (w_alu_flags)
    );

    // Response capture at the end of EXEC; held unchanged through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_id     <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_rsp_result <= w_alu_result;
            r_rsp_flags  <= w_alu_flags;
            r_rsp_id     <= r_id;
        end
    end

    // Completed-handshake counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_cnt <= '0;
        end else if (w_rsp_hs) begin
            r_done_cnt <= r_done_cnt + CNT_W'(1);
        end
    end

    assign rsp_valid  = (r_state == ST_RESP);
    assign busy       = (r_state != ST_IDLE);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign done_cnt   = r_done_cnt;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench. A round-robin instance is the
//               main target; a fixed-priority instance with a 2-bit counter
//               shares its inputs to cover priority mode and counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] samt;
        logic [7:0] res;
        logic [3:0] flg;   // {overflow, negative, zero, carry}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic [3:0] req0_samt, req1_samt;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_flags;
    logic [15:0] done_cnt;

    logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_busy;
    logic [7:0]  f_rsp_result;
    logic [3:0]  f_rsp_flags;
    logic [1:0]  f_done_cnt;

    int total = 0;
    int bad   = 0;
    vec_t vecs [12];

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_samt(req0_samt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_samt(req1_samt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy), .done_cnt(done_cnt)
    );

    alu_arbiter #(.RR_EN(0), .CNT_W(2)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_samt(req0_samt),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_samt(req1_samt),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
        .rsp_result(f_rsp_result), .rsp_flags(f_rsp_flags), .busy(f_busy), .done_cnt(f_done_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] samt);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_samt = samt;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_samt = samt;
        end
    endtask

    // Called just after a negedge; two rising edges with reset high
    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete operation from an idle DUT with rsp_ready held high
    task automatic run_vec(input vec_t v, input logic [15:0] exp_cnt);
        set_req(v.id, v.op, v.a, v.b, v.samt);
        #1;
        chk("vec_ready", v.id ? req1_ready : req0_ready, 1);
        @(negedge clk);                       // T+1 : EXEC
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("vec_exec_valid", rsp_valid, 0);
        chk("vec_exec_busy", busy, 1);
        @(negedge clk);                       // T+2 : RESP
        chk("vec_rsp_valid", rsp_valid, 1);
        chk("vec_rsp_id", rsp_id, v.id);
        chk("vec_result", rsp_result, v.res);
        chk("vec_flags", rsp_flags, v.flg);
        @(negedge clk);                       // after the handshake
        chk("vec_rsp_drop", rsp_valid, 0);
        chk("vec_done_cnt", done_cnt, exp_cnt);
    endtask

    initial begin
        int  found;
        int  last_seen;
        int  cyc;

        vecs[0]  = '{1'b0, 3'b000, 8'h7F, 8'h01, 4'd0, 8'h80, 4'b1100};
        vecs[1]  = '{1'b1, 3'b001, 8'h05, 8'h05, 4'd0, 8'h00, 4'b0011};
        vecs[2]  = '{1'b0, 3'b100, 8'h03, 8'h01, 4'd2, 8'h10, 4'b0000};
        vecs[3]  = '{1'b1, 3'b110, 8'h03, 8'h01, 4'd2, 8'h01, 4'b0000};
        vecs[4]  = '{1'b0, 3'b010, 8'hF0, 8'h3C, 4'd0, 8'h30, 4'b0000};
        vecs[5]  = '{1'b1, 3'b011, 8'h01, 8'hF0, 4'd0, 8'hF1, 4'b0100};
        vecs[6]  = '{1'b0, 3'b101, 8'h01, 8'h02, 4'd4, 8'hF0, 4'b0100};
        vecs[7]  = '{1'b1, 3'b111, 8'h80, 8'h01, 4'd3, 8'h0F, 4'b1001};
        vecs[8]  = '{1'b0, 3'b000, 8'hFF, 8'h01, 4'd0, 8'h00, 4'b0011};
        vecs[9]  = '{1'b1, 3'b100, 8'h01, 8'h01, 4'd8, 8'h00, 4'b0010};
        vecs[10] = '{1'b0, 3'b001, 8'h00, 8'h01, 4'd0, 8'hFF, 4'b0100};
        vecs[11] = '{1'b1, 3'b000, 8'h80, 8'h80, 4'd0, 8'h00, 4'b1011};

        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; req0_samt = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; req1_samt = '0;

        // Reset state, and no ready while reset is high
        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table of single-requester operations
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], 16'(i + 1));
        end

        // Both requesters valid continuously: RR alternates, fixed priority stays on 0
        reset_dut();
        set_req(1'b0, 3'b000, 8'h01, 8'h01, 4'd0);
        set_req(1'b1, 3'b000, 8'h01, 8'h01, 4'd0);
        last_seen = 0;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int w = 0; w < 8 && found == 0; w++) begin
                @(negedge clk);
                cyc++;
                if (rsp_valid) found = 1;
            end
            if (found == 0) begin
                chk("rr_timeout", 0, 1);
                break;
            end
            chk("rr_id", rsp_id, k % 2);
            chk("rr_result", rsp_result, 8'h02);
            chk("fp_valid", f_rsp_valid, 1);
            chk("fp_id", f_rsp_id, 0);
            chk("fp_result", f_rsp_result, 8'h02);
            chk("fp_flags", f_rsp_flags, 4'b0000);
            chk("fp_busy", f_busy, 1);
            if (k > 0) chk("rr_gap", cyc - last_seen, 3);
            last_seen = cyc;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_done_cnt", done_cnt, 4);
        chk("fp_done_wrap", f_done_cnt, 0);

        // Consumer stall for five cycles in RESP
        reset_dut();
        rsp_ready = 1'b0;
        set_req(1'b0, 3'b000, 8'h10, 8'h20, 4'd0);
        set_req(1'b1, 3'b001, 8'h44, 8'h11, 4'd0);
        @(negedge clk);                       // EXEC
        req0_a = 8'hAA;                       // changes while not accepted: no effect
        req1_b = 8'h55;
        @(negedge clk);                       // RESP
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_result", rsp_result, 8'h30);
            chk("stall_flags", rsp_flags, 4'b0000);
            chk("stall_id", rsp_id, 0);
            chk("stall_ready0", req0_ready, 0);
            chk("stall_ready1", req1_ready, 0);
            chk("stall_busy", busy, 1);
            chk("stall_cnt", done_cnt, 0);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", rsp_valid, 0);
        chk("release_busy", busy, 0);
        chk("release_cnt", done_cnt, 1);

        // Reset during EXEC discards the operation and restores requester 0 priority
        reset_dut();
        set_req(1'b0, 3'b000, 8'h01, 8'h02, 4'd0);
        @(negedge clk);                       // EXEC
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("abort_valid", rsp_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_cnt", done_cnt, 0);
            @(negedge clk);
        end
        set_req(1'b0, 3'b001, 8'h09, 8'h03, 4'd0);
        set_req(1'b1, 3'b010, 8'hFF, 8'hFF, 4'd0);
        #1;
        chk("post_ready0", req0_ready, 1);
        chk("post_ready1", req1_ready, 0);
        chk("post_fp_ready0", f_req0_ready, 1);
        chk("post_fp_ready1", f_req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("post_valid", rsp_valid, 1);
        chk("post_id", rsp_id, 0);
        chk("post_result", rsp_result, 8'h06);
        chk("post_flags", rsp_flags, 4'b0001);
        @(negedge clk);
        chk("post_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire
